// File: rtl/alu_scoreboard.sv
// alu_scoreboard: passive monitor for the serial two-operand ALU interface.
// It captures operand A with opcode bit 0 and then operand B with opcode bit 1
// over two opcode_valid beats, predicts the result and overflow, and runs five
// enable-gated checks: reset, input protocol, done latency, result, overflow.
// Error pulses are registered. Sticky flags and saturating counters are
// maintained alongside them. Stats are cleared only by clear_stats.
module alu_scoreboard #(
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_LATENCY = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear_stats,
    input  logic [4:0]            check_en,
    input  logic                  opcode_valid,
    input  logic                  opcode,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [DATA_WIDTH-1:0] result,
    input  logic                  overflow,
    input  logic                  done,
    output logic                  busy,
    output logic [4:0]            err_pulse,
    output logic [4:0]            err_sticky,
    output logic [CNT_WIDTH-1:0]  pass_cnt,
    output logic [CNT_WIDTH-1:0]  fail_cnt
);

    localparam int LAT_W = $clog2(MAX_LATENCY + 1) + 1;
    localparam logic [LAT_W-1:0]     LAT_ONE  = {{(LAT_W-1){1'b0}}, 1'b1};
    localparam logic [LAT_W-1:0]     LAT_ZERO = {LAT_W{1'b0}};
    localparam logic [LAT_W-1:0]     LAT_MAX  = LAT_W'(MAX_LATENCY);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_GOT_A     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    // True when any bit of the beat is X or Z; the reduction XOR propagates
    // any unknown bit into an unknown parity.
    function automatic logic has_unknown(input logic [DATA_WIDTH:0] beat);
        return ((^beat) === 1'bx);
    endfunction

    state_t                state_r;
    state_t                state_next_s;
    logic [DATA_WIDTH-1:0] a_r;
    logic [DATA_WIDTH-1:0] a_next_s;
    logic [DATA_WIDTH-1:0] b_r;
    logic [DATA_WIDTH-1:0] b_next_s;
    logic [1:0]            op_r;
    logic [1:0]            op_next_s;
    logic [LAT_W-1:0]      lat_cnt_r;
    logic [LAT_W-1:0]      lat_next_s;
    logic [LAT_W-1:0]      lat_inc_s;
    logic                  rst_d_r;
    logic                  busy_r;
    logic [4:0]            err_pulse_r;
    logic [4:0]            err_sticky_r;
    logic [CNT_WIDTH-1:0]  pass_cnt_r;
    logic [CNT_WIDTH-1:0]  fail_cnt_r;
    logic [4:0]            chk_s;
    logic [4:0]            err_next_s;
    logic                  done_ok_s;
    logic [DATA_WIDTH:0]   pred_s;
    logic [DATA_WIDTH-1:0] exp_result_s;
    logic                  exp_ov_s;

    assign busy       = busy_r;
    assign err_pulse  = err_pulse_r;
    assign err_sticky = err_sticky_r;
    assign pass_cnt   = pass_cnt_r;
    assign fail_cnt   = fail_cnt_r;
    assign lat_inc_s  = lat_cnt_r + LAT_ONE;

    // Predict result and overflow from the buffered operands and opcode.
    always_comb begin
        pred_s = {(DATA_WIDTH+1){1'b0}};
        case (op_r)
            2'b00:   pred_s = {1'b0, a_r} + {1'b0, b_r};
            2'b01:   pred_s = {1'b0, a_r} - {1'b0, b_r};
            2'b10:   pred_s = {1'b0, a_r ^ b_r};
            2'b11:   pred_s = {1'b0, ~(a_r ^ b_r)};
            default: pred_s = {(DATA_WIDTH+1){1'b0}};
        endcase
        exp_result_s = pred_s[DATA_WIDTH-1:0];
        exp_ov_s     = pred_s[DATA_WIDTH];
    end

    // Next-state, operand capture and raw check evaluation.
    always_comb begin
        state_next_s = state_r;
        a_next_s     = a_r;
        b_next_s     = b_r;
        op_next_s    = op_r;
        lat_next_s   = lat_cnt_r;
        chk_s        = 5'b00000;
        done_ok_s    = 1'b0;
        if (!reset_n) begin
            // Only the reset check may fire. The first reset cycle is excused
            // because the DUT has not yet seen its own reset.
            chk_s[0]     = rst_d_r & ((result != DATA_ZERO) | overflow | done);
            state_next_s = ST_IDLE;
            a_next_s     = DATA_ZERO;
            b_next_s     = DATA_ZERO;
            op_next_s    = 2'b00;
            lat_next_s   = LAT_ZERO;
        end else begin
            if (opcode_valid && has_unknown({opcode, data})) begin
                chk_s[1] = 1'b1;
            end else begin
                chk_s[1] = 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    chk_s[2] = done;
                    if (opcode_valid) begin
                        a_next_s     = data;
                        op_next_s[0] = opcode;
                        state_next_s = ST_GOT_A;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_GOT_A: begin
                    chk_s[2] = done;
                    if (opcode_valid) begin
                        b_next_s     = data;
                        op_next_s[1] = opcode;
                        lat_next_s   = LAT_ZERO;
                        state_next_s = ST_WAIT_DONE;
                    end else begin
                        state_next_s = ST_GOT_A;
                    end
                end
                ST_WAIT_DONE: begin
                    if (opcode_valid) begin
                        // A new beat while waiting drops the pending operation
                        // and restarts capture with this beat as operand A.
                        chk_s[1]     = 1'b1;
                        a_next_s     = data;
                        op_next_s[0] = opcode;
                        lat_next_s   = LAT_ZERO;
                        state_next_s = ST_GOT_A;
                    end else if (done) begin
                        done_ok_s    = 1'b1;
                        chk_s[3]     = (result != exp_result_s);
                        chk_s[4]     = (overflow != exp_ov_s);
                        lat_next_s   = LAT_ZERO;
                        state_next_s = ST_IDLE;
                    end else if (lat_inc_s == LAT_MAX) begin
                        chk_s[2]     = 1'b1;
                        lat_next_s   = LAT_ZERO;
                        state_next_s = ST_IDLE;
                    end else begin
                        lat_next_s   = lat_inc_s;
                        state_next_s = ST_WAIT_DONE;
                    end
                end
                default: begin
                    lat_next_s   = LAT_ZERO;
                    state_next_s = ST_IDLE;
                end
            endcase
        end
        err_next_s = chk_s & check_en;
    end

    // Remember whether the previous cycle was in reset; deliberately unreset.
    always_ff @(posedge clk) begin
        rst_d_r <= ~reset_n;
    end

    // FSM, operand buffers, busy and error pulse registers.
    always_ff @(posedge clk) begin
        state_r     <= state_next_s;
        a_r         <= a_next_s;
        b_r         <= b_next_s;
        op_r        <= op_next_s;
        lat_cnt_r   <= lat_next_s;
        busy_r      <= (state_next_s != ST_IDLE);
        err_pulse_r <= err_next_s;
    end

    // Sticky flags and saturating counters; untouched by reset_n.
    always_ff @(posedge clk) begin
        if (clear_stats) begin
            err_sticky_r <= 5'b00000;
            pass_cnt_r   <= CNT_ZERO;
            fail_cnt_r   <= CNT_ZERO;
        end else begin
            err_sticky_r <= err_sticky_r | err_next_s;
            if ((err_next_s != 5'b00000) && !(&fail_cnt_r)) begin
                fail_cnt_r <= fail_cnt_r + CNT_ONE;
            end else begin
                fail_cnt_r <= fail_cnt_r;
            end
            if (done_ok_s && (err_next_s == 5'b00000) && !(&pass_cnt_r)) begin
                pass_cnt_r <= pass_cnt_r + CNT_ONE;
            end else begin
                pass_cnt_r <= pass_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_alu_scoreboard.sv
// Directed testbench for alu_scoreboard: each task drives one scenario and
// checks the registered outputs one time unit after the clock edge.
module tb_alu_scoreboard;

    logic        clk;
    logic        reset_n;
    logic        clear_stats;
    logic [4:0]  check_en;
    logic        opcode_valid;
    logic        opcode;
    logic [7:0]  data;
    logic [7:0]  result;
    logic        overflow;
    logic        done;
    logic        busy;
    logic [4:0]  err_pulse;
    logic [4:0]  err_sticky;
    logic [15:0] pass_cnt;
    logic [15:0] fail_cnt;

    int tests_run;
    int tests_failed;

    alu_scoreboard #(
        .DATA_WIDTH (8),
        .MAX_LATENCY(2),
        .CNT_WIDTH  (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear_stats (clear_stats),
        .check_en    (check_en),
        .opcode_valid(opcode_valid),
        .opcode      (opcode),
        .data        (data),
        .result      (result),
        .overflow    (overflow),
        .done        (done),
        .busy        (busy),
        .err_pulse   (err_pulse),
        .err_sticky  (err_sticky),
        .pass_cnt    (pass_cnt),
        .fail_cnt    (fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic op, input logic [7:0] d);
        opcode_valid = 1'b1;
        opcode       = op;
        data         = d;
        tick();
        opcode_valid = 1'b0;
        opcode       = 1'b0;
        data         = 8'h00;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; clear_stats = 1'b1;
        tick(); tick();
        reset_n = 1'b1; clear_stats = 1'b0;
        tick();
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests_run++;
        if (err_pulse !== 5'b00000) begin tests_failed++; $display("FAIL reset_err: got %b want 00000", err_pulse); end
        tests_run++;
        if (pass_cnt !== 16'd0 || fail_cnt !== 16'd0) begin
            tests_failed++; $display("FAIL reset_cnt: got pass=%0d fail=%0d want 0/0", pass_cnt, fail_cnt);
        end
        tests_run++;
        if (err_sticky !== 5'b00000) begin tests_failed++; $display("FAIL reset_sticky: got %b want 00000", err_sticky); end
    endtask

    task automatic test_add();
        beat(1'b0, 8'hF0);
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL add_busy: got %b want 1", busy); end
        beat(1'b0, 8'h20);
        tick();
        done = 1'b1; result = 8'h10; overflow = 1'b1;
        tick();
        done = 1'b0;
        tests_run++;
        if (err_pulse !== 5'b00000) begin tests_failed++; $display("FAIL add_err: got %b want 00000", err_pulse); end
        tests_run++;
        if (pass_cnt !== 16'd1) begin tests_failed++; $display("FAIL add_pass: got %0d want 1", pass_cnt); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL add_idle: got %b want 0", busy); end
    endtask

    task automatic test_sub();
        beat(1'b1, 8'h10);
        beat(1'b0, 8'h20);
        done = 1'b1; result = 8'hF0; overflow = 1'b1;
        tick();
        done = 1'b0;
        tests_run++;
        if (err_pulse !== 5'b00000 || pass_cnt !== 16'd2) begin
            tests_failed++; $display("FAIL sub_pass: got err=%b pass=%0d want 00000/2", err_pulse, pass_cnt);
        end
        beat(1'b1, 8'h10);
        beat(1'b0, 8'h20);
        done = 1'b1; result = 8'hE0; overflow = 1'b1;
        tick();
        done = 1'b0;
        tests_run++;
        if (err_pulse !== 5'b01000) begin tests_failed++; $display("FAIL sub_bad_err: got %b want 01000", err_pulse); end
        tests_run++;
        if (fail_cnt !== 16'd1 || pass_cnt !== 16'd2) begin
            tests_failed++; $display("FAIL sub_bad_cnt: got fail=%0d pass=%0d want 1/2", fail_cnt, pass_cnt);
        end
        tests_run++;
        if (err_sticky !== 5'b01000) begin tests_failed++; $display("FAIL sub_sticky: got %b want 01000", err_sticky); end
        tick();
        tests_run++;
        if (err_pulse !== 5'b00000) begin tests_failed++; $display("FAIL sub_pulse_len: got %b want 00000", err_pulse); end
    endtask

    task automatic test_xnor();
        beat(1'b1, 8'hAA);
        beat(1'b1, 8'h0F);
        done = 1'b1; result = 8'h5A; overflow = 1'b1;
        tick();
        done = 1'b0; overflow = 1'b0;
        tests_run++;
        if (err_pulse !== 5'b10000) begin tests_failed++; $display("FAIL xnor_err: got %b want 10000", err_pulse); end
        tests_run++;
        if (fail_cnt !== 16'd2 || err_sticky !== 5'b11000) begin
            tests_failed++; $display("FAIL xnor_stats: got fail=%0d sticky=%b want 2/11000", fail_cnt, err_sticky);
        end
    endtask

    task automatic test_timeout();
        beat(1'b0, 8'h01);
        beat(1'b0, 8'h02);
        tick();
        tests_run++;
        if (err_pulse !== 5'b00000 || busy !== 1'b1) begin
            tests_failed++; $display("FAIL to_first: got err=%b busy=%b want 00000/1", err_pulse, busy);
        end
        tick();
        tests_run++;
        if (err_pulse !== 5'b00100) begin tests_failed++; $display("FAIL to_err: got %b want 00100", err_pulse); end
        done = 1'b1; result = 8'h03;
        tick();
        done = 1'b0; result = 8'h00;
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL to_busy: got %b want 0", busy); end
        tests_run++;
        if (err_pulse !== 5'b00100 || fail_cnt !== 16'd4) begin
            tests_failed++; $display("FAIL to_spurious: got err=%b fail=%0d want 00100/4", err_pulse, fail_cnt);
        end
    endtask

    task automatic test_reset_check();
        done = 1'b1; reset_n = 1'b0;
        tick();
        tests_run++;
        if (err_pulse !== 5'b00000) begin tests_failed++; $display("FAIL rst_c1: got %b want 00000", err_pulse); end
        tick();
        tests_run++;
        if (err_pulse !== 5'b00001) begin tests_failed++; $display("FAIL rst_c2: got %b want 00001", err_pulse); end
        tick();
        tests_run++;
        if (err_pulse !== 5'b00001 || fail_cnt !== 16'd6) begin
            tests_failed++; $display("FAIL rst_c3: got err=%b fail=%0d want 00001/6", err_pulse, fail_cnt);
        end
        done = 1'b0; reset_n = 1'b1;
        tick();
        check_en = 5'b11110; done = 1'b1; reset_n = 1'b0;
        tick(); tick(); tick();
        tests_run++;
        if (err_pulse !== 5'b00000 || fail_cnt !== 16'd6) begin
            tests_failed++; $display("FAIL rst_disabled: got err=%b fail=%0d want 00000/6", err_pulse, fail_cnt);
        end
        done = 1'b0; reset_n = 1'b1; check_en = 5'b11111;
        tick();
        beat(1'b0, 8'h01);
        beat(1'b0, 8'h02);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tests_run++;
        if (busy !== 1'b0 || err_pulse !== 5'b00000) begin
            tests_failed++; $display("FAIL rst_abort: got busy=%b err=%b want 0/00000", busy, err_pulse);
        end
        done = 1'b1; result = 8'h03;
        tick();
        done = 1'b0; result = 8'h00;
        tests_run++;
        if (err_pulse !== 5'b00100 || fail_cnt !== 16'd7 || pass_cnt !== 16'd2) begin
            tests_failed++;
            $display("FAIL rst_abort_done: got err=%b fail=%0d pass=%0d want 00100/7/2", err_pulse, fail_cnt, pass_cnt);
        end
    endtask

    task automatic test_protocol();
        beat(1'b0, 8'h05);
        beat(1'b0, 8'h03);
        beat(1'b1, 8'h10);
        tests_run++;
        if (err_pulse !== 5'b00010 || busy !== 1'b1) begin
            tests_failed++; $display("FAIL proto_err: got err=%b busy=%b want 00010/1", err_pulse, busy);
        end
        beat(1'b0, 8'h20);
        done = 1'b1; result = 8'hF0; overflow = 1'b1;
        tick();
        done = 1'b0; overflow = 1'b0; result = 8'h00;
        tests_run++;
        if (err_pulse !== 5'b00000 || pass_cnt !== 16'd3 || fail_cnt !== 16'd8) begin
            tests_failed++;
            $display("FAIL proto_newa: got err=%b pass=%0d fail=%0d want 00000/3/8", err_pulse, pass_cnt, fail_cnt);
        end
        tests_run++;
        if (err_sticky !== 5'b11111) begin tests_failed++; $display("FAIL proto_sticky: got %b want 11111", err_sticky); end
        beat(1'b0, 8'h01);
        beat(1'b0, 8'h02);
        opcode_valid = 1'b1; opcode = 1'b0; data = 8'hxx; clear_stats = 1'b1;
        tick();
        opcode_valid = 1'b0; data = 8'h00; clear_stats = 1'b0;
        tests_run++;
        if (err_pulse !== 5'b00010) begin tests_failed++; $display("FAIL xclr_err: got %b want 00010", err_pulse); end
        tests_run++;
        if (err_sticky !== 5'b00000 || fail_cnt !== 16'd0 || pass_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL xclr_stats: got sticky=%b fail=%0d pass=%0d want 00000/0/0", err_sticky, fail_cnt, pass_cnt);
        end
        tick();
        tests_run++;
        if (busy !== 1'b1 || err_sticky !== 5'b00000) begin
            tests_failed++; $display("FAIL xclr_after: got busy=%b sticky=%b want 1/00000", busy, err_sticky);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        reset_n = 1'b0; clear_stats = 1'b0; check_en = 5'b11111;
        opcode_valid = 1'b0; opcode = 1'b0; data = 8'h00;
        result = 8'h00; overflow = 1'b0; done = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_xnor();
        test_timeout();
        test_reset_check();
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
